// File: rtl/led_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyph codes and the
// nibble-to-glyph lookup used by every display path.
package led_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      4'hF:    hex_to_seg = SEG_F;
      default: hex_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to {g,f,e,d,c,b,a} active-high segment decoder.
module seg7_hex_decoder
  import led_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  assign o_segments = hex_to_seg(i_nibble);

endmodule

// File: rtl/led_scan_driver.sv
// N-digit multiplexed 7-segment scanner with frame-coherent input snapshot,
// PWM brightness, per-digit blink, leading-zero blanking and a dark dead cycle per slot.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_LOG2    = 10,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      blank_leading,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [6:0]                segments,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     choice_n,
  output logic                      frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT_ONE  = NUM_DIGITS'(32'd1);

  logic [SCAN_LOG2-1:0]    r_p;
  logic [IDX_W-1:0]        r_idx;
  logic [BLINK_W-1:0]      r_blink_cnt;
  logic                    r_blink_phase;

  logic [4*NUM_DIGITS-1:0] r_digits_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_mask_sh;
  logic                    r_blank_sh;
  logic [PWM_BITS-1:0]     r_bright_sh;
  logic                    r_phase_sh;

  logic                    w_start;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_lead_zero;
  logic                    w_zero_run;
  logic [PWM_BITS-1:0]     w_pwm_field;
  logic                    w_pwm_on;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_sel_n;

  assign w_start = (r_p == {SCAN_LOG2{1'b0}}) && (r_idx == {IDX_W{1'b0}});

  // Slot position and digit index counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p   <= {SCAN_LOG2{1'b0}};
      r_idx <= {IDX_W{1'b0}};
    end else begin
      r_p <= r_p + SCAN_LOG2'(32'd1);
      if (r_p == {SCAN_LOG2{1'b1}}) begin
        r_idx <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_W'(32'd1);
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Frame-start snapshot of inputs and blink phase; the shadowed phase is the
  // one in force before this frame's wrap, so a wrap takes effect one frame later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_digits_sh   <= {(4*NUM_DIGITS){1'b0}};
      r_dp_sh       <= {NUM_DIGITS{1'b0}};
      r_mask_sh     <= {NUM_DIGITS{1'b0}};
      r_blank_sh    <= 1'b0;
      r_bright_sh   <= {PWM_BITS{1'b0}};
      r_phase_sh    <= 1'b0;
      r_blink_cnt   <= {BLINK_W{1'b0}};
      r_blink_phase <= 1'b0;
    end else if (w_start) begin
      r_digits_sh <= digits_in;
      r_dp_sh     <= dp_in;
      r_mask_sh   <= blink_mask;
      r_blank_sh  <= blank_leading;
      r_bright_sh <= brightness;
      r_phase_sh  <= r_blink_phase;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= {BLINK_W{1'b0}};
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BLINK_W'(32'd1);
        r_blink_phase <= r_blink_phase;
      end
    end else begin
      r_digits_sh   <= r_digits_sh;
      r_dp_sh       <= r_dp_sh;
      r_mask_sh     <= r_mask_sh;
      r_blank_sh    <= r_blank_sh;
      r_bright_sh   <= r_bright_sh;
      r_phase_sh    <= r_phase_sh;
      r_blink_cnt   <= r_blink_cnt;
      r_blink_phase <= r_blink_phase;
    end
  end

  // Leading-zero mask: walk from the MSD down while every nibble seen is zero
  always_comb begin
    w_lead_zero = {NUM_DIGITS{1'b0}};
    w_zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run     = w_zero_run & (r_digits_sh[4*i +: 4] == 4'h0);
      w_lead_zero[i] = r_blank_sh & w_zero_run & (i != 32'sd0);
    end
  end

  assign w_nibble    = r_digits_sh[{r_idx, 2'b00} +: 4];
  assign w_pwm_field = r_p[SCAN_LOG2-1 -: PWM_BITS];
  assign w_pwm_on    = (w_pwm_field < r_bright_sh) || (r_bright_sh == {PWM_BITS{1'b1}});
  assign w_lit       = (r_p != {SCAN_LOG2{1'b0}}) && w_pwm_on &&
                       !(r_phase_sh && r_mask_sh[r_idx]) && !w_lead_zero[r_idx];
  assign w_sel_n     = ~(DIGIT_ONE << r_idx);

  seg7_hex_decoder u_decoder (
    .i_nibble   (w_nibble),
    .o_segments (w_seg)
  );

  // Registered pin drivers; every dark condition collapses to all-off
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      choice_n    <= {NUM_DIGITS{1'b1}};
      segments    <= 7'h00;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_start;
      if (w_lit) begin
        choice_n <= w_sel_n;
        segments <= w_seg;
        dp       <= r_dp_sh[r_idx];
      end else begin
        choice_n <= {NUM_DIGITS{1'b1}};
        segments <= 7'h00;
        dp       <= 1'b0;
      end
    end
  end

endmodule
